// File: rtl/image_proc_pkg.sv
// Shared definitions for the image processing path: colour class codes,
// classifier FSM states and RGB332 field positions.
package image_proc_pkg;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_RED   = 2'd1,
    CLS_GREEN = 2'd2,
    CLS_BLUE  = 2'd3
  } colour_cls_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam int RED_MSB   = 7;
  localparam int RED_LSB   = 5;
  localparam int GREEN_MSB = 4;
  localparam int GREEN_LSB = 2;
  localparam int BLUE_MSB  = 1;
  localparam int BLUE_LSB  = 0;

  // Blue has one bit less than red/green; replicate its MSB so all three compare on 3 bits.
  function automatic logic [2:0] expand_blue(input logic [1:0] blue);
    return {blue, blue[1]};
  endfunction

endpackage

// File: rtl/rgb332_classifier.sv
// Strictly-largest-of-three selector. Used on pixel channels and on band/frame counts;
// any tie for the maximum yields CLS_NONE.
module rgb332_classifier
  import image_proc_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] red,
  input  logic [W-1:0] green,
  input  logic [W-1:0] blue,
  output logic [1:0]   cls
);

  // Pick the channel that beats both others.
  always_comb begin
    cls = CLS_NONE;
    if ((red > green) && (red > blue)) begin
      cls = CLS_RED;
    end else if ((green > red) && (green > blue)) begin
      cls = CLS_GREEN;
    end else if ((blue > red) && (blue > green)) begin
      cls = CLS_BLUE;
    end else begin
      cls = CLS_NONE;
    end
  end

endmodule

// File: rtl/image_band_histogram.sv
// Streaming RGB332 colour classifier with per-band histograms and a one-deep result register.
// Optional frame-wide dominant class enabled by IMAGE_BAND_HIST_FRAME_SUM_EN.
module image_band_histogram
  import image_proc_pkg::*;
#(
  parameter int SCREEN_WIDTH = 176,
  parameter int BAND_HEIGHT  = 6,
  parameter int NUM_BANDS    = 24,
  parameter int COUNT_W      = 11,
  parameter int ADDR_W       = 15,
  localparam int BAND_W      = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FRAME_START,
  input  logic [7:0]         PIXEL_IN,
  input  logic               PIXEL_VALID,
  output logic [ADDR_W-1:0]  READ_ADDRESS_NEXT,
  output logic               BUSY,
  output logic               RESULT_VALID,
  input  logic               RESULT_READY,
  output logic [BAND_W-1:0]  RESULT_BAND,
  output logic [COUNT_W-1:0] RESULT_RED,
  output logic [COUNT_W-1:0] RESULT_GREEN,
  output logic [COUNT_W-1:0] RESULT_BLUE,
  output logic [1:0]         RESULT_DOMINANT,
  output logic               FRAME_DONE,
  output logic               OVERFLOW,
  output logic [1:0]         FRAME_DOMINANT
);

  localparam int BAND_PIX = SCREEN_WIDTH * BAND_HEIGHT;
  localparam int PIX_W    = (BAND_PIX > 1) ? $clog2(BAND_PIX) : 1;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(BAND_PIX - 1);
  localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(NUM_BANDS - 1);

  state_t state, state_next;

  logic [PIX_W-1:0]   pix_idx, base_pix;
  logic [BAND_W-1:0]  band_idx, base_band;
  logic [ADDR_W-1:0]  base_addr;
  logic [COUNT_W-1:0] cnt_red, cnt_green, cnt_blue;
  logic [COUNT_W-1:0] nxt_red, nxt_green, nxt_blue;
  logic [2:0]         pix_blue;
  logic [1:0]         pix_cls, band_dom;
  logic               take, hit_red, hit_green, hit_blue, band_end, frame_end;

  assign pix_blue = expand_blue(PIXEL_IN[BLUE_MSB:BLUE_LSB]);

  rgb332_classifier #(.W(3)) u_pixel_cls (
    .red   (PIXEL_IN[RED_MSB:RED_LSB]),
    .green (PIXEL_IN[GREEN_MSB:GREEN_LSB]),
    .blue  (pix_blue),
    .cls   (pix_cls)
  );

  rgb332_classifier #(.W(COUNT_W)) u_band_cls (
    .red   (nxt_red),
    .green (nxt_green),
    .blue  (nxt_blue),
    .cls   (band_dom)
  );

  // FRAME_START rebases everything to zero first so a same-cycle pixel becomes pixel 0 of band 0.
  always_comb begin
    base_pix  = FRAME_START ? {PIX_W{1'b0}}   : pix_idx;
    base_band = FRAME_START ? {BAND_W{1'b0}}  : band_idx;
    base_addr = FRAME_START ? {ADDR_W{1'b0}}  : READ_ADDRESS_NEXT;
    take      = PIXEL_VALID && (FRAME_START || (state == ST_ACCUM));
    hit_red   = take && (pix_cls == CLS_RED);
    hit_green = take && (pix_cls == CLS_GREEN);
    hit_blue  = take && (pix_cls == CLS_BLUE);
    nxt_red   = (FRAME_START ? {COUNT_W{1'b0}} : cnt_red)   + {{(COUNT_W-1){1'b0}}, hit_red};
    nxt_green = (FRAME_START ? {COUNT_W{1'b0}} : cnt_green) + {{(COUNT_W-1){1'b0}}, hit_green};
    nxt_blue  = (FRAME_START ? {COUNT_W{1'b0}} : cnt_blue)  + {{(COUNT_W-1){1'b0}}, hit_blue};
    band_end  = take && (base_pix == PIX_LAST);
    frame_end = band_end && (base_band == BAND_LAST);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a restart while accumulating stays in ACCUM.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (FRAME_START && !frame_end) state_next = ST_ACCUM;
        else                           state_next = ST_IDLE;
      end
      ST_ACCUM: begin
        if (frame_end) state_next = ST_IDLE;
        else           state_next = ST_ACCUM;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Pixel/band indices, address, band accumulators and the result register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pix_idx           <= {PIX_W{1'b0}};
      band_idx          <= {BAND_W{1'b0}};
      READ_ADDRESS_NEXT <= {ADDR_W{1'b0}};
      cnt_red           <= {COUNT_W{1'b0}};
      cnt_green         <= {COUNT_W{1'b0}};
      cnt_blue          <= {COUNT_W{1'b0}};
      BUSY              <= 1'b0;
      RESULT_VALID      <= 1'b0;
      RESULT_BAND       <= {BAND_W{1'b0}};
      RESULT_RED        <= {COUNT_W{1'b0}};
      RESULT_GREEN      <= {COUNT_W{1'b0}};
      RESULT_BLUE       <= {COUNT_W{1'b0}};
      RESULT_DOMINANT   <= 2'b00;
      FRAME_DONE        <= 1'b0;
      OVERFLOW          <= 1'b0;
    end else begin
      BUSY       <= (state_next == ST_ACCUM);
      FRAME_DONE <= frame_end;
      if (band_end) begin
        pix_idx   <= {PIX_W{1'b0}};
        band_idx  <= frame_end ? {BAND_W{1'b0}} : base_band + {{(BAND_W-1){1'b0}}, 1'b1};
        cnt_red   <= {COUNT_W{1'b0}};
        cnt_green <= {COUNT_W{1'b0}};
        cnt_blue  <= {COUNT_W{1'b0}};
      end else begin
        pix_idx   <= base_pix + {{(PIX_W-1){1'b0}}, take};
        band_idx  <= base_band;
        cnt_red   <= nxt_red;
        cnt_green <= nxt_green;
        cnt_blue  <= nxt_blue;
      end
      if (frame_end) begin
        READ_ADDRESS_NEXT <= {ADDR_W{1'b0}};
      end else begin
        READ_ADDRESS_NEXT <= base_addr + {{(ADDR_W-1){1'b0}}, take};
      end
      if (band_end) begin
        RESULT_VALID    <= 1'b1;
        RESULT_BAND     <= base_band;
        RESULT_RED      <= nxt_red;
        RESULT_GREEN    <= nxt_green;
        RESULT_BLUE     <= nxt_blue;
        RESULT_DOMINANT <= band_dom;
      end else if (RESULT_VALID && RESULT_READY) begin
        RESULT_VALID <= 1'b0;
      end else begin
        RESULT_VALID <= RESULT_VALID;
      end
      // A completion that replaces an unaccepted result is the only overflow source.
      if (band_end && RESULT_VALID && !RESULT_READY) begin
        OVERFLOW <= 1'b1;
      end else if (FRAME_START) begin
        OVERFLOW <= 1'b0;
      end else begin
        OVERFLOW <= OVERFLOW;
      end
    end
  end

`ifdef IMAGE_BAND_HIST_FRAME_SUM_EN
  logic [COUNT_W-1:0] sum_red, sum_green, sum_blue;
  logic [COUNT_W-1:0] sum_red_nxt, sum_green_nxt, sum_blue_nxt;
  logic [1:0]         frame_cls;

  // Frame-wide totals include the pixel being accepted this cycle.
  always_comb begin
    sum_red_nxt   = (FRAME_START ? {COUNT_W{1'b0}} : sum_red)   + {{(COUNT_W-1){1'b0}}, hit_red};
    sum_green_nxt = (FRAME_START ? {COUNT_W{1'b0}} : sum_green) + {{(COUNT_W-1){1'b0}}, hit_green};
    sum_blue_nxt  = (FRAME_START ? {COUNT_W{1'b0}} : sum_blue)  + {{(COUNT_W-1){1'b0}}, hit_blue};
  end

  rgb332_classifier #(.W(COUNT_W)) u_frame_cls (
    .red   (sum_red_nxt),
    .green (sum_green_nxt),
    .blue  (sum_blue_nxt),
    .cls   (frame_cls)
  );

  // Frame accumulators; the frame class is held until the next frame completes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sum_red        <= {COUNT_W{1'b0}};
      sum_green      <= {COUNT_W{1'b0}};
      sum_blue       <= {COUNT_W{1'b0}};
      FRAME_DOMINANT <= 2'b00;
    end else if (frame_end) begin
      sum_red        <= {COUNT_W{1'b0}};
      sum_green      <= {COUNT_W{1'b0}};
      sum_blue       <= {COUNT_W{1'b0}};
      FRAME_DOMINANT <= frame_cls;
    end else begin
      sum_red        <= sum_red_nxt;
      sum_green      <= sum_green_nxt;
      sum_blue       <= sum_blue_nxt;
      FRAME_DOMINANT <= FRAME_DOMINANT;
    end
  end
`else
  assign FRAME_DOMINANT = 2'b00;
`endif

endmodule

// File: tb/tb_image_band_histogram.sv
// Self-checking bench for image_band_histogram: directed scenarios plus random traffic
// compared against a pixel-queue reference model.
module tb_image_band_histogram;

  localparam int SW = 4;
  localparam int BH = 2;
  localparam int NB = 3;
  localparam int CW = 11;
  localparam int AW = 15;
  localparam int BP = SW * BH;
  localparam int FP = BP * NB;

  logic          CLK, RESET, FRAME_START, PIXEL_VALID, RESULT_READY;
  logic [7:0]    PIXEL_IN;
  logic [AW-1:0] READ_ADDRESS_NEXT;
  logic          BUSY, RESULT_VALID, FRAME_DONE, OVERFLOW;
  logic [1:0]    RESULT_BAND, RESULT_DOMINANT, FRAME_DOMINANT;
  logic [CW-1:0] RESULT_RED, RESULT_GREEN, RESULT_BLUE;

  image_band_histogram #(
    .SCREEN_WIDTH(SW), .BAND_HEIGHT(BH), .NUM_BANDS(NB), .COUNT_W(CW), .ADDR_W(AW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FRAME_START(FRAME_START), .PIXEL_IN(PIXEL_IN),
    .PIXEL_VALID(PIXEL_VALID), .READ_ADDRESS_NEXT(READ_ADDRESS_NEXT), .BUSY(BUSY),
    .RESULT_VALID(RESULT_VALID), .RESULT_READY(RESULT_READY), .RESULT_BAND(RESULT_BAND),
    .RESULT_RED(RESULT_RED), .RESULT_GREEN(RESULT_GREEN), .RESULT_BLUE(RESULT_BLUE),
    .RESULT_DOMINANT(RESULT_DOMINANT), .FRAME_DONE(FRAME_DONE), .OVERFLOW(OVERFLOW),
    .FRAME_DOMINANT(FRAME_DOMINANT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Reference model: frame position, pixels of the current band, frame totals, expected outputs.
  bit         m_active = 1'b0;
  int         m_pcnt = 0;
  logic [7:0] band_q[$];
  int         fr_cnt[4];
  int e_valid = 0, e_band = 0, e_red = 0, e_green = 0, e_blue = 0, e_dom = 0;
  int e_done = 0, e_ovf = 0, e_fdom = 0;

  // Unique maximum of three wins; any shared maximum means no class.
  function automatic int dom3(input int r, input int g, input int b);
    int m, n;
    m = (r > g) ? r : g;
    m = (m > b) ? m : b;
    n = int'(r == m) + int'(g == m) + int'(b == m);
    if (n != 1) return 0;
    if (r == m) return 1;
    if (g == m) return 2;
    return 3;
  endfunction

  function automatic int pix_class(input logic [7:0] p);
    logic [2:0] b3;
    b3 = {p[1:0], p[1]};
    return dom3(int'(p[7:5]), int'(p[4:2]), int'(b3));
  endfunction

  task automatic step(input bit rs, input bit fs, input bit pv, input logic [7:0] px, input bit rdy);
    int  cnt[4];
    bit  hs, loaded;
    RESET = rs; FRAME_START = fs; PIXEL_VALID = pv; PIXEL_IN = px; RESULT_READY = rdy;
    e_done = 0;
    if (rs) begin
      m_active = 0; m_pcnt = 0; band_q.delete();
      fr_cnt = '{default: 0};
      e_valid = 0; e_band = 0; e_red = 0; e_green = 0; e_blue = 0; e_dom = 0;
      e_ovf = 0; e_fdom = 0;
    end else begin
      hs = (e_valid != 0) && rdy;
      loaded = 0;
      if (fs) begin
        m_active = 1; m_pcnt = 0; band_q.delete(); e_ovf = 0;
        fr_cnt = '{default: 0};
      end
      if (m_active && pv) begin
        band_q.push_back(px);
        fr_cnt[pix_class(px)]++;
        m_pcnt++;
        if (band_q.size() == BP) begin
          cnt = '{default: 0};
          foreach (band_q[i]) cnt[pix_class(band_q[i])]++;
          if ((e_valid != 0) && !rdy) e_ovf = 1;
          e_valid = 1; e_band = (m_pcnt - 1) / BP;
          e_red = cnt[1]; e_green = cnt[2]; e_blue = cnt[3];
          e_dom = dom3(cnt[1], cnt[2], cnt[3]);
          band_q.delete();
          loaded = 1;
        end
        if (m_pcnt == FP) begin
          m_active = 0; m_pcnt = 0; e_done = 1;
`ifdef IMAGE_BAND_HIST_FRAME_SUM_EN
          e_fdom = dom3(fr_cnt[1], fr_cnt[2], fr_cnt[3]);
`endif
        end
      end
      if (!loaded && hs) e_valid = 0;
    end
    @(negedge CLK);
    check_eq("addr",      32'(READ_ADDRESS_NEXT), 32'(m_pcnt));
    check_eq("busy",      32'(BUSY),              32'(m_active));
    check_eq("res_valid", 32'(RESULT_VALID),      32'(e_valid));
    check_eq("res_band",  32'(RESULT_BAND),       32'(e_band));
    check_eq("res_red",   32'(RESULT_RED),        32'(e_red));
    check_eq("res_green", 32'(RESULT_GREEN),      32'(e_green));
    check_eq("res_blue",  32'(RESULT_BLUE),       32'(e_blue));
    check_eq("res_dom",   32'(RESULT_DOMINANT),   32'(e_dom));
    check_eq("frame_done",32'(FRAME_DONE),        32'(e_done));
    check_eq("overflow",  32'(OVERFLOW),          32'(e_ovf));
    check_eq("frame_dom", 32'(FRAME_DOMINANT),    32'(e_fdom));
  endtask

  logic [7:0] mix[FP];
  logic [7:0] tmp;

  initial begin
    RESET = 1'b1; FRAME_START = 1'b0; PIXEL_VALID = 1'b0; PIXEL_IN = 8'h00; RESULT_READY = 1'b1;
    step(1, 0, 0, 8'h00, 1);
    step(1, 0, 0, 8'h00, 1);

    // Pixels while idle must not move anything.
    repeat (3) step(0, 0, 1, 8'($urandom), 1);

    // Solid red frame.
    step(0, 1, 0, 8'h00, 1);
    for (int i = 0; i < FP; i++) step(0, 0, 1, 8'hE0, 1);
    step(0, 0, 0, 8'h00, 1);
    check_eq("red_frame_addr_wrap", 32'(READ_ADDRESS_NEXT), 32'd0);

    // Green/blue tie in band 0, start pixel shares the FRAME_START cycle.
    step(0, 1, 1, 8'h1C, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'h1C, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h03, 1);
    check_eq("tie_dom", 32'(RESULT_DOMINANT), 32'd0);
    for (int i = 0; i < 2 * BP; i++)
      step(0, 0, 1, (i % 3 == 0) ? 8'h92 : ((i % 3 == 1) ? 8'h00 : 8'h91), 1);

    // Consumer stalled across two completions.
    step(0, 1, 0, 8'h00, 1);
    for (int i = 0; i < 2 * BP; i++) step(0, 0, 1, 8'($urandom), 0);
    step(0, 0, 0, 8'h00, 0);
    check_eq("ovf_set", 32'(OVERFLOW), 32'd1);
    check_eq("ovf_band", 32'(RESULT_BAND), 32'd1);
    step(0, 1, 0, 8'h00, 1);
    for (int i = 0; i < FP; i++) step(0, 0, 1, 8'($urandom), 1);

    // Restart mid-band.
    step(0, 1, 0, 8'h00, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom), 1);
    step(0, 1, 0, 8'h00, 1);
    for (int i = 0; i < FP; i++) step(0, 0, 1, 8'($urandom), 1);

    // Reset while a result is held, then idle pixels are ignored.
    step(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < BP + 2; i++) step(0, 0, 1, 8'hE0, 0);
    step(1, 0, 1, 8'hE0, 0);
    repeat (4) step(0, 0, 1, 8'($urandom), 1);

    // 10 blue, 8 red, 6 green in shuffled order.
    for (int i = 0; i < FP; i++) mix[i] = (i < 10) ? 8'h03 : ((i < 18) ? 8'hE0 : 8'h1C);
    for (int i = FP - 1; i > 0; i--) begin
      int j;
      j = $urandom_range(0, i);
      tmp = mix[i]; mix[i] = mix[j]; mix[j] = tmp;
    end
    step(0, 1, 0, 8'h00, 1);
    for (int i = 0; i < FP; i++) step(0, 0, 1, mix[i], 1);
    step(0, 0, 0, 8'h00, 1);

    // Random traffic: gaps, back-pressure, restarts and occasional reset.
    step(0, 1, 0, 8'h00, 1);
    for (int i = 0; i < 800; i++) begin
      bit rs, fs, pv, rdy;
      rs  = ($urandom_range(0, 299) == 0);
      fs  = ($urandom_range(0, 49) == 0);
      pv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      step(rs, fs, pv, 8'($urandom), rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
